// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector issue queue between the scalar core and vector decode.
package riscv_v_pkg;

    localparam int XLEN             = 32;
    localparam int RISCV_V_IQ_DEPTH = 4;
    localparam int RISCV_V_IQ_AFULL = 3;

    typedef logic [31:0]     riscv_instruction_t;
    typedef logic [XLEN-1:0] riscv_data_t;

    // addi x0,x0,0 shown to decode whenever the queue has nothing to offer
    localparam riscv_instruction_t RISCV_V_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        riscv_instruction_t instr;
        riscv_data_t        scalar;
    } riscv_v_iq_entry_t;

endpackage

// File: rtl/riscv_v_iq_ctrl.sv
// Pointer, occupancy and handshake control for the vector issue queue.
module riscv_v_iq_ctrl #(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_pipe,
    input  logic                       push_valid,
    input  logic                       riscv_v_stall,
    output logic                       push_ready,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic                       instr_valid_id,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic pop;

    // Ready is derived from the registered count only, so decode stall never reaches the core combinationally.
    assign push_ready     = (count != CW'(DEPTH));
    assign empty          = (count == '0);
    assign almost_full    = (count >= CW'(AFULL_LEVEL));
    assign instr_valid_id = !empty;
    assign wr_en          = push_valid && push_ready && !clear_pipe;
    assign pop            = instr_valid_id && !riscv_v_stall;

    always_ff @(posedge clk) begin
        if (rst || clear_pipe) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)
                count <= count + CW'(1);
            else if (pop && !wr_en)
                count <= count - CW'(1);
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(wr_en && count == CW'(DEPTH)));
    a_count_bounded:     assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_empty_consistent:  assert property (@(posedge clk) disable iff (rst) (count == '0) == empty);

endmodule

// File: rtl/riscv_v_issue_queue.sv
// Issue queue decoupling scalar-core pushes of vector instructions from vector decode stalls.
module riscv_v_issue_queue
    import riscv_v_pkg::*;
#(
    parameter int DEPTH       = RISCV_V_IQ_DEPTH,
    parameter int AFULL_LEVEL = RISCV_V_IQ_AFULL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_pipe,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  riscv_instruction_t       push_instr,
    input  riscv_data_t              push_scalar,
    input  logic                     riscv_v_stall,
    output logic                     instr_valid_id,
    output riscv_instruction_t       instruction_id,
    output riscv_data_t              int_rf_rd_data_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     empty
);

    logic                       wr_en;
    logic [$clog2(DEPTH)-1:0]   wr_ptr;
    logic [$clog2(DEPTH)-1:0]   rd_ptr;
    riscv_v_iq_entry_t          entries [DEPTH];

    riscv_v_iq_ctrl #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .clear_pipe     (clear_pipe),
        .push_valid     (push_valid),
        .riscv_v_stall  (riscv_v_stall),
        .push_ready     (push_ready),
        .wr_en          (wr_en),
        .wr_ptr         (wr_ptr),
        .rd_ptr         (rd_ptr),
        .instr_valid_id (instr_valid_id),
        .count          (count),
        .almost_full    (almost_full),
        .empty          (empty)
    );

    // Storage is not reset; stale slots are masked by the valid-gated output mux.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_ptr].instr  <= push_instr;
            entries[wr_ptr].scalar <= push_scalar;
        end
    end

    always_comb begin
        instruction_id    = RISCV_V_NOP_INSTR;
        int_rf_rd_data_id = '0;
        if (instr_valid_id) begin
            instruction_id    = entries[rd_ptr].instr;
            int_rf_rd_data_id = entries[rd_ptr].scalar;
        end
    end

endmodule

// File: tb/tb_riscv_v_issue_queue.sv
// Scenario and randomized checks of the vector issue queue against a queue-based reference model.
module tb_riscv_v_issue_queue;
    import riscv_v_pkg::*;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear_pipe = 1'b0;
    logic              push_valid = 1'b0;
    logic              push_ready;
    logic [31:0]       push_instr = '0;
    logic [XLEN-1:0]   push_scalar = '0;
    logic              riscv_v_stall = 1'b0;
    logic              instr_valid_id;
    logic [31:0]       instruction_id;
    logic [XLEN-1:0]   int_rf_rd_data_id;
    logic [2:0]        count;
    logic              almost_full;
    logic              empty;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mq[$];

    always #5 clk = ~clk;

    riscv_v_issue_queue #(.DEPTH(DEPTH), .AFULL_LEVEL(AF)) dut (
        .clk               (clk),
        .rst               (rst),
        .clear_pipe        (clear_pipe),
        .push_valid        (push_valid),
        .push_ready        (push_ready),
        .push_instr        (push_instr),
        .push_scalar       (push_scalar),
        .riscv_v_stall     (riscv_v_stall),
        .instr_valid_id    (instr_valid_id),
        .instruction_id    (instruction_id),
        .int_rf_rd_data_id (int_rf_rd_data_id),
        .count             (count),
        .almost_full       (almost_full),
        .empty             (empty)
    );

    wire [70:0] dut_vec = {instr_valid_id, instruction_id, int_rf_rd_data_id,
                           count, push_ready, almost_full, empty};

    // Observable state implied by the model queue contents
    function automatic logic [70:0] model_vec();
        int n = mq.size();
        logic [63:0] head = (n > 0) ? mq[0] : {RISCV_V_NOP_INSTR, 32'h0};
        return {n > 0, head[63:32], head[31:0], 3'(n), n < DEPTH, n >= AF, n == 0};
    endfunction

    // Advance the model by the current inputs, then let the DUT take the same edge.
    task automatic tick();
        bit do_pop, do_push;
        if (rst || clear_pipe) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && !riscv_v_stall;
            do_push = push_valid && (mq.size() < DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({push_instr, push_scalar});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dut_vec !== {1'b0, RISCV_V_NOP_INSTR, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec,
                     {1'b0, RISCV_V_NOP_INSTR, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_single();
        push_valid = 1'b1; push_instr = 32'h0221_00D7; push_scalar = 32'h55; riscv_v_stall = 1'b0;
        tick();
        push_valid = 1'b0;
        vectors++;
        if ({instr_valid_id, instruction_id, int_rf_rd_data_id} !== {1'b1, 32'h0221_00D7, 32'h55}) begin
            miscompares++;
            $display("FAIL single_head got=%h_%h_%h exp=1_022100d7_00000055",
                     instr_valid_id, instruction_id, int_rf_rd_data_id);
        end
        tick();
        vectors++;
        if ({empty, instruction_id, int_rf_rd_data_id} !== {1'b1, RISCV_V_NOP_INSTR, 32'h0}) begin
            miscompares++;
            $display("FAIL single_drain got=%h_%h_%h exp=1_00000013_00000000",
                     empty, instruction_id, int_rf_rd_data_id);
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_instr;
        riscv_v_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_instr = 32'hA000_0000 + 32'(i); push_scalar = 32'(i * 3);
            tick();
            vectors++;
            if ({count, push_ready, almost_full} !==
                {3'((i < 4) ? i + 1 : 4), (i + 1) < DEPTH, (i + 1) >= AF}) begin
                miscompares++;
                $display("FAIL fill_level push=%0d got cnt=%0d rdy=%b af=%b", i, count, push_ready, almost_full);
            end
        end
        push_valid = 1'b0; riscv_v_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_instr = 32'hA000_0000 + 32'(i);
            vectors++;
            if ({instruction_id, int_rf_rd_data_id} !== {exp_instr, 32'(i * 3)}) begin
                miscompares++;
                $display("FAIL fill_order idx=%0d got=%h/%h exp=%h/%h", i, instruction_id,
                         int_rf_rd_data_id, exp_instr, 32'(i * 3));
            end
            tick();
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drained empty=%b exp=1", empty);
        end
    endtask

    task automatic test_full_wrap();
        riscv_v_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_instr = 32'hB000_0000 + 32'(i); push_scalar = 32'h100 + 32'(i);
            tick();
        end
        riscv_v_stall = 1'b0;
        for (int i = 4; i < 10; i++) begin
            push_instr = 32'hB000_0000 + 32'(i); push_scalar = 32'h100 + 32'(i);
            tick();
            vectors++;
            if (count !== 3'd3) begin
                miscompares++;
                $display("FAIL wrap_count step=%0d got=%0d exp=3", i, count);
            end
        end
        push_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL wrap_drain step=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            tick();
        end
    endtask

    task automatic test_clear();
        riscv_v_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_instr = 32'hC000_0000 + 32'(i); push_scalar = 32'(i);
            tick();
        end
        clear_pipe = 1'b1; push_instr = 32'hC0DE_0000;
        tick();
        clear_pipe = 1'b0; push_valid = 1'b0;
        vectors++;
        if ({count, empty, instruction_id} !== {3'd0, 1'b1, RISCV_V_NOP_INSTR}) begin
            miscompares++;
            $display("FAIL clear_flush got cnt=%0d empty=%b instr=%h exp 0/1/00000013", count, empty, instruction_id);
        end
        riscv_v_stall = 1'b0;
        tick();
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_push_dropped empty=%b exp=1", empty);
        end
    endtask

    task automatic test_rst_clear();
        riscv_v_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_valid = 1'b1; push_instr = 32'hD000_0000 + 32'(i); push_scalar = 32'(i);
            tick();
        end
        push_valid = 1'b0;
        vectors++;
        if (count !== 3'd2) begin
            miscompares++;
            $display("FAIL rst_pre_count got=%0d exp=2", count);
        end
        rst = 1'b1; clear_pipe = 1'b1;
        tick();
        rst = 1'b0; clear_pipe = 1'b0; riscv_v_stall = 1'b0;
        vectors++;
        if (dut_vec !== {1'b0, RISCV_V_NOP_INSTR, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_with_clear got=%h exp=%h", dut_vec,
                     {1'b0, RISCV_V_NOP_INSTR, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            push_valid    = ($urandom_range(0, 99) < 60);
            riscv_v_stall = ($urandom_range(0, 99) < 40);
            clear_pipe    = ($urandom_range(0, 199) == 0);
            rst           = ($urandom_range(0, 999) == 0);
            push_instr    = $urandom();
            push_scalar   = $urandom();
            tick();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL random cycle=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
        end
        rst = 1'b0; clear_pipe = 1'b0; push_valid = 1'b0; riscv_v_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_wrap();
        test_clear();
        test_rst_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
